reg_file_2r1w: RTL and testbench
================================

Name: reg_file_2r1w

Overview:
- MIPS general-purpose register file: 32 x 32-bit storage with two combinational read ports (rs, rt) and one synchronous write port (rd).
- Sits between decode (read addresses) and writeback (write port) in the datapath.
- Unlike the free-running pipeline registers, entries update only when write-enabled and addressed.
- Register 0 is hardwired to zero.

Parameters:
- WIDTH, 32, data width of each entry in bits.
- DEPTH, 32, number of entries; must be a power of two and at least 2.
- ADDR_W, $clog2(DEPTH), address width; derived and not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset; clears all entries.
- we  input  1  write enable, sampled at the rising edge of clk.
- waddr  input  ADDR_W  write address (rd).
- wdata  input  WIDTH  write data.
- raddr_a  input  ADDR_W  read address, port A (rs).
- rdata_a  output  WIDTH  read data, port A.
- raddr_b  input  ADDR_W  read address, port B (rt).
- rdata_b  output  WIDTH  read data, port B.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high; ports are named clk and rst.
- Reset: at a rising edge with rst=1, every entry becomes 0. rdata_a and rdata_b therefore read 0 after that edge for every address.
- Reset priority: rst overrides we in the same cycle, so no write occurs. Reset asserted mid-sequence discards any pending write.
- Write: at a rising edge with rst=0, we=1 and waddr!=0, entry[waddr] <= wdata. The new value is visible on the read ports after that edge (1-cycle write latency).
- Writes with we=0, or with waddr=0, leave all storage unchanged.
- Read: combinational with zero-cycle latency. rdata_x = (raddr_x==0) ? 0 : entry[raddr_x]. Both ports are independent, and both may address the same entry.
- Entry 0: never stored. It may be implemented as constant 0, but it must read 0 under all conditions, including while we=1 and waddr=0 with nonzero wdata.
- Same-cycle read/write of the same nonzero address: behaviour is set by the optional feature below.
- No X propagation: every entry has a defined value after the first reset edge. Before the first reset, contents are unspecified, and the bench must not check them.

Optional Feature:
- Macro: REG_FILE_WRITE_BYPASS_EN.
- Defined: if we=1, rst=0 and waddr==raddr_x!=0, then rdata_x = wdata combinationally in the same cycle as the write. This is write-then-read semantics and removes the writeback-to-decode hazard.
- Undefined: rdata_x returns the old entry value until the clock edge (read-then-write). The hazard unit must stall or forward in that case.
- Bypass never applies to address 0 or while rst=1.

Decomposition:
- Shared package mips_pkg:
  - constants REG_ADDR_W=5, REG_COUNT=32, REG_ZERO=5'd0, WORD_W=32;
  - typedef word_t (logic [WORD_W-1:0]);
  - typedef reg_addr_t (logic [REG_ADDR_W-1:0]).
- Sub-module reg_file_entry: one WIDTH-bit register with synchronous reset and a write enable, generated DEPTH-1 times (entries 1..DEPTH-1).
- A write-address decoder drives the per-entry enables.
- The read muxes and the bypass logic live in the top module.

Test Plan:
- Reset then read: rst=1 for 1 cycle, then sweep raddr_a/raddr_b over 0..31 -> all return 0x00000000.
- Write then read: we=1, waddr=5, wdata=0xDEADBEEF for one edge; then raddr_a=5, raddr_b=5 -> both 0xDEADBEEF; raddr_a=6 -> 0.
- Zero register: we=1, waddr=0, wdata=0xFFFFFFFF -> rdata_a at raddr_a=0 is 0, both during and after the edge; no other entry changes.
- Same-cycle read/write: entry 9 holds 0x11111111; we=1, waddr=9, wdata=0x22222222, raddr_a=9 -> before the edge reads 0x22222222 with REG_FILE_WRITE_BYPASS_EN and 0x11111111 without; after the edge reads 0x22222222 in both builds.
- Reset beats write: entry 3 holds 0xA5A5A5A5; one edge with rst=1, we=1, waddr=3, wdata=0x12345678 -> entry 3 reads 0, and the bypass output is 0 while rst=1.
- Full sweep: write entry i = i*0x01010101 for i=1..31, then read all entries through both ports in reverse order -> exact match with no aliasing; write with we=0 to entry 7 -> value unchanged (0x07070707).

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
// Module : mips_pkg
// Brief  : Shared MIPS datapath constants and register-file types.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int                 REG_ADDR_W = 5;
    localparam int                 REG_COUNT  = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam int                 WORD_W     = 32;

    typedef logic [WORD_W-1:0]     word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

`default_nettype wire

// File: rtl/reg_file_entry.sv
// ============================================================================
// Module : reg_file_entry
// Brief  : One register-file entry; synchronous reset dominates write enable.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file_entry #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/reg_file_2r1w.sv
// ============================================================================
// Module : reg_file_2r1w
// Brief  : MIPS GPR file, two combinational reads, one synchronous write,
//          entry 0 hardwired to zero. Macro REG_FILE_WRITE_BYPASS_EN enables
//          same-cycle write-to-read forwarding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file_2r1w
    import mips_pkg::*;
#(
    parameter int WIDTH  = WORD_W,
    parameter int DEPTH  = REG_COUNT,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b
);

    logic [WIDTH-1:0] w_entry [DEPTH];
    logic [DEPTH-1:1] w_wen;
    logic [WIDTH-1:0] w_rdata_a;
    logic [WIDTH-1:0] w_rdata_b;

    // Entry 0 has no storage; reading it always yields zero.
    assign w_entry[0] = '0;

    for (genvar i = 1; i < DEPTH; i++) begin : g_entry
        assign w_wen[i] = we && (waddr == ADDR_W'(i));

        reg_file_entry #(
            .WIDTH (WIDTH)
        ) u_entry (
            .clk  (clk),
            .rst  (rst),
            .i_en (w_wen[i]),
            .i_d  (wdata),
            .o_q  (w_entry[i])
        );
    end

`ifdef REG_FILE_WRITE_BYPASS_EN
    logic w_byp_a;
    logic w_byp_b;

    // Forwarding never targets entry 0 and is suppressed during reset.
    assign w_byp_a = we && !rst && (waddr != '0) && (waddr == raddr_a);
    assign w_byp_b = we && !rst && (waddr != '0) && (waddr == raddr_b);

    always_comb begin
        w_rdata_a = w_byp_a ? wdata : w_entry[raddr_a];
        w_rdata_b = w_byp_b ? wdata : w_entry[raddr_b];
    end
`else
    always_comb begin
        w_rdata_a = w_entry[raddr_a];
        w_rdata_b = w_entry[raddr_b];
    end
`endif

    assign rdata_a = w_rdata_a;
    assign rdata_b = w_rdata_b;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_2r1w.sv
// ============================================================================
// Module : tb_reg_file_2r1w
// Brief  : Self-checking bench for reg_file_2r1w (vector table + sequences).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_file_2r1w;

`ifdef REG_FILE_WRITE_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    typedef struct {
        logic [31:0] ea;
        logic [31:0] eb;
        string       tag;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr_a;
    logic [31:0] rdata_a;
    logic [4:0]  raddr_b;
    logic [31:0] rdata_b;

    int   checks;
    int   errors;
    exp_t sb[$];
    vec_t tbl[7];

    reg_file_2r1w u_dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (raddr_a),
        .rdata_a (rdata_a),
        .raddr_b (raddr_b),
        .rdata_b (rdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs, check reads before the edge, then take the edge.
    task automatic step(input logic r, input logic w, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] ra,
                        input logic [4:0] rb, input logic [31:0] ea,
                        input logic [31:0] eb, input string tag);
        exp_t e;
        rst     = r;
        we      = w;
        waddr   = wa;
        wdata   = wd;
        raddr_a = ra;
        raddr_b = rb;
        e.ea  = ea;
        e.eb  = eb;
        e.tag = tag;
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        checks++;
        if (rdata_a !== e.ea) begin
            errors++;
            $display("FAIL %s port_a raddr=%0d got=%08h exp=%08h", e.tag, ra, rdata_a, e.ea);
        end
        checks++;
        if (rdata_b !== e.eb) begin
            errors++;
            $display("FAIL %s port_b raddr=%0d got=%08h exp=%08h", e.tag, rb, rdata_b, e.eb);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd6, 32'h0,        32'h0};
        tbl[1] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2] = '{1'b0, 5'd0, 32'h0,        5'd6, 5'd5, 32'h0,        32'hDEADBEEF};
        tbl[3] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF};
        tbl[4] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 32'h0,        32'h0};
        tbl[5] = '{1'b1, 5'd9, 32'h11111111, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0};
        tbl[6] = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd9, 32'h11111111, 32'h11111111};

        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 32'h0, 32'h0, "reset_sweep");
        end

        for (int i = 0; i < 7; i++) begin
            step(1'b0, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra, tbl[i].rb,
                 tbl[i].ea, tbl[i].eb, $sformatf("vec%0d", i));
        end

        // Same-cycle read/write on entry 9.
        step(1'b0, 1'b1, 5'd9, 32'h22222222, 5'd9, 5'd5,
             c_BYP ? 32'h22222222 : 32'h11111111, 32'hDEADBEEF, "rw_same_pre");
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 32'h22222222, 32'h22222222, "rw_same_post");

        // Reset wins over a same-cycle write; bypass is suppressed while rst=1.
        step(1'b0, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd0, 5'd9, 32'h0, 32'h22222222, "rst_prep");
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 32'hA5A5A5A5, 32'hA5A5A5A5, "rst_hold");
        step(1'b1, 1'b1, 5'd3, 32'h12345678, 5'd3, 5'd9, 32'hA5A5A5A5, 32'h22222222, "rst_write_pre");
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd9, 32'h0, 32'h0, "rst_write_post");

        for (int i = 1; i < 32; i++) begin
            step(1'b0, 1'b1, 5'(i), 32'(i) * 32'h01010101, 5'(i - 1), 5'd0,
                 32'(i - 1) * 32'h01010101, 32'h0, "sweep_wr");
        end
        for (int i = 31; i >= 0; i--) begin
            step(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i),
                 32'(i) * 32'h01010101, 32'(i) * 32'h01010101, "sweep_rd");
        end

        step(1'b0, 1'b0, 5'd7, 32'hCAFEF00D, 5'd7, 5'd8, 32'h07070707, 32'h08080808, "we0_pre");
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 32'h07070707, 32'h0, "we0_post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
